// File: rtl/res_mem_ctrl_if.sv
// Request/grant and read-return bundle between the result RAM
// arbiter and its two clients (datapath writer, host reader).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 128
`endif

interface res_mem_ctrl_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    // Client side: raises requests, receives grants and read data
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_gnt, rd_gnt, rd_valid, rd_data
    );

    // Arbiter side
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_gnt, rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/res_mem_ctrl.sv
// Arbiter and sequencer for the single-port result RAM. Shares the RAM
// port between the datapath writer and the host reader (round-robin on
// contention) and runs a self-timed sweep that zeroes every word.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 128
`endif

module res_mem_ctrl #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int TOTAL_ADDR = `TOTAL_ADDR
) (
    input  logic                  clock,
    input  logic                  reset,
    res_mem_ctrl_if.slave         bus,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(TOTAL_ADDR - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  last_rd, last_rd_nxt;  // 1: read won the last contended cycle
    logic                  clr_done_nxt;
    logic                  wr_gnt, rd_gnt;
    logic                  vld_p1, vld_p2;

    // State, sweep counter, round-robin flag and done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SERVE;
            cnt      <= '0;
            last_rd  <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_rd  <= last_rd_nxt;
            clr_done <= clr_done_nxt;
        end
    end

    // Arbitration, sweep sequencing and RAM port mux
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_rd_nxt  = last_rd;
        clr_done_nxt = 1'b0;
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        busy         = 1'b0;
        ram_address  = '0;
        ram_data     = '0;
        ram_wren     = 1'b0;
        unique case (state)
            SERVE: begin
                // On a tie, write wins unless it won the previous tie
                if (!reset) begin
                    if (bus.wr_req && (!bus.rd_req || last_rd)) begin
                        wr_gnt = 1'b1;
                    end else if (bus.rd_req) begin
                        rd_gnt = 1'b1;
                    end
                end
                if (bus.wr_req && bus.rd_req) begin
                    last_rd_nxt = rd_gnt;
                end
                if (wr_gnt) begin
                    ram_address = bus.wr_addr;
                    ram_data    = bus.wr_data;
                    ram_wren    = 1'b1;
                end else if (rd_gnt) begin
                    ram_address = bus.rd_addr;
                end
                if (clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                busy        = 1'b1;
                ram_address = cnt;
                ram_wren    = !reset;
                cnt_nxt     = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt    = SERVE;
                    cnt_nxt      = '0;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = SERVE;
        endcase
    end

    // Read-return valid pipe: stage 1 = address in RAM, stage 2 = q valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= rd_gnt;
            vld_p2 <= vld_p1;
        end
    end

    assign bus.wr_gnt   = wr_gnt;
    assign bus.rd_gnt   = rd_gnt;
    assign bus.rd_valid = vld_p2;
    assign bus.rd_data  = ram_q;
endmodule

// File: tb/tb_res_mem_ctrl.sv
// Bench for res_mem_ctrl: a registered-output RAM stand-in, a per-cycle
// behavioural reference (memory image, tie-break owner, remaining sweep
// words, read-return queue), directed scenarios with literal expectations
// and a randomized phase with occasional clears and resets.
module tb_res_mem_ctrl;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int TOTAL = 128;

    logic          clock;
    logic          reset;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    int checks = 0;
    int errors = 0;

    res_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    res_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_ADDR(TOTAL)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .clr_start   (clr_start),
        .busy        (busy),
        .clr_done    (clr_done),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM stand-in: address registered at the edge, q registered one edge later
    logic [DW-1:0] tmem [TOTAL];
    logic [AW-1:0] t_a1;
    initial begin
        for (int i = 0; i < TOTAL; i++) tmem[i] = '0;
        t_a1  = '0;
        ram_q = '0;
    end
    always @(posedge clock) begin
        if (ram_wren) tmem[ram_address] <= ram_data;
        t_a1  <= ram_address;
        ram_q <= tmem[t_a1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_mem [TOTAL];
    int            m_clr_left;   // sweep words still to write; 0 = serving
    bit            m_done;       // clr_done expected this cycle
    bit            m_last_wr;    // write won the most recent tie
    bit            m_v1, m_v2;
    logic [DW-1:0] m_d1, m_d2;

    // Compare process: checks every output at the falling edge, then advances the model
    initial begin : model
        bit            busy_e, gw, gr, done_n;
        logic [AW-1:0] a_e;
        for (int i = 0; i < TOTAL; i++) m_mem[i] = '0;
        m_clr_left = 0; m_done = 0; m_last_wr = 0; m_v1 = 0; m_v2 = 0;
        m_d1 = '0; m_d2 = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_clr_left = 0; m_done = 0; m_last_wr = 0; m_v1 = 0; m_v2 = 0;
                chk("rst_wr_gnt", bus.wr_gnt, 0);
                chk("rst_rd_gnt", bus.rd_gnt, 0);
                chk("rst_ram_wren", ram_wren, 0);
                chk("rst_busy", busy, 0);
                chk("rst_clr_done", clr_done, 0);
                chk("rst_rd_valid", bus.rd_valid, 0);
            end else begin
                busy_e = (m_clr_left > 0);
                gw = !busy_e && bus.wr_req && (!bus.rd_req || !m_last_wr);
                gr = !busy_e && bus.rd_req && (!bus.wr_req || m_last_wr);
                chk("wr_gnt", bus.wr_gnt, gw);
                chk("rd_gnt", bus.rd_gnt, gr);
                chk("busy", busy, busy_e);
                chk("clr_done", clr_done, m_done);
                chk("rd_valid", bus.rd_valid, m_v2);
                if (m_v2) chk("rd_data", bus.rd_data, m_d2);
                if (busy_e) begin
                    a_e = AW'(TOTAL - m_clr_left);
                    chk("ram_wren", ram_wren, 1);
                    chk("ram_address", ram_address, a_e);
                    chk("ram_data", ram_data, 0);
                end else if (gw) begin
                    chk("ram_wren", ram_wren, 1);
                    chk("ram_address", ram_address, bus.wr_addr);
                    chk("ram_data", ram_data, bus.wr_data);
                end else if (gr) begin
                    chk("ram_wren", ram_wren, 0);
                    chk("ram_address", ram_address, bus.rd_addr);
                end else begin
                    chk("ram_wren", ram_wren, 0);
                    chk("ram_address", ram_address, 0);
                    chk("ram_data", ram_data, 0);
                end
                // advance
                if (bus.wr_req && bus.rd_req && !busy_e) m_last_wr = gw;
                m_v2 = m_v1; m_d2 = m_d1;
                m_v1 = gr;   m_d1 = m_mem[bus.rd_addr];
                done_n = (m_clr_left == 1);
                if (busy_e) begin
                    m_mem[TOTAL - m_clr_left] = '0;
                    m_clr_left--;
                end else begin
                    if (gw) m_mem[bus.wr_addr] = bus.wr_data;
                    if (clr_start) m_clr_left = TOTAL;
                end
                m_done = done_n;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr_req = 0; bus.rd_req = 0; clr_start = 0;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < TOTAL; i++) begin
            bus.wr_req  = 1;
            bus.wr_addr = AW'(i);
            bus.wr_data = (i == 3) ? 32'h3333_3333 : v;
            step();
        end
        bus.wr_req = 0;
    endtask

    // Stimulus with literal expectations for the directed scenarios
    initial begin : stim
        logic [3:0] wg, rg, we;
        logic [6:0] rv;
        int bfirst, blast, bcnt, dcnt, dcyc, gcnt, nv, nz;
        bit pend_w, pend_r;

        reset = 1; idle();
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        step();
        @(negedge clock);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_rd_valid", bus.rd_valid, 0);
        step();
        reset = 0;

        // single write then read of the same word
        bus.wr_req = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clock); chk("lit_w_gnt_c0", bus.wr_gnt, 1);
        step();
        bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 5;
        @(negedge clock); chk("lit_r_gnt_c1", bus.rd_gnt, 1);
        step();
        bus.rd_req = 0;
        step();
        @(negedge clock);
        chk("lit_rd_valid_c3", bus.rd_valid, 1);
        chk("lit_rd_data_c3", bus.rd_data, 32'hDEAD_BEEF);
        step();

        // contention: both held for four cycles
        wg = 0; rg = 0; we = 0; rv = 0;
        for (int c = 0; c < 7; c++) begin
            bus.wr_req = (c < 4); bus.wr_addr = 1; bus.wr_data = 32'h1111_1111;
            bus.rd_req = (c < 4); bus.rd_addr = 2;
            @(negedge clock);
            if (c < 4) begin wg[c] = bus.wr_gnt; rg[c] = bus.rd_gnt; we[c] = ram_wren; end
            rv[c] = bus.rd_valid;
            step();
        end
        chk("lit_cont_wr_gnt", {28'd0, wg}, 32'h5);
        chk("lit_cont_rd_gnt", {28'd0, rg}, 32'hA);
        chk("lit_cont_wren", {28'd0, we}, 32'h5);
        chk("lit_cont_rd_valid", {25'd0, rv}, 32'h28);
        idle();

        // clear sweep with in-flight read, ignored second start, blocked requests
        fill(32'hA5A5_A5A5);
        bfirst = -1; blast = -1; bcnt = 0; dcnt = 0; dcyc = -1; gcnt = 0;
        for (int c = 0; c < 136; c++) begin
            clr_start   = (c == 0 || c == 50);
            bus.rd_req  = (c <= 128);
            bus.rd_addr = (c == 0) ? 7'd3 : 7'd7;
            @(negedge clock);
            if (c == 0) chk("lit_clr_rd_gnt_c0", bus.rd_gnt, 1);
            if (c == 2) begin
                chk("lit_inflight_valid", bus.rd_valid, 1);
                chk("lit_inflight_data", bus.rd_data, 32'h3333_3333);
            end
            if (busy) begin
                bcnt++; blast = c;
                if (bfirst < 0) bfirst = c;
            end
            if (clr_done) begin dcnt++; dcyc = c; end
            if (c >= 1 && c <= 128 && (bus.wr_gnt || bus.rd_gnt)) gcnt++;
            step();
        end
        idle();
        chk("lit_busy_first", bfirst, 1);
        chk("lit_busy_last", blast, 128);
        chk("lit_busy_count", bcnt, 128);
        chk("lit_done_count", dcnt, 1);
        chk("lit_done_cycle", dcyc, 129);
        chk("lit_grants_in_clear", gcnt, 0);

        // read back the whole RAM
        nv = 0; nz = 0;
        for (int c = 0; c < 131; c++) begin
            bus.rd_req = (c < TOTAL); bus.rd_addr = AW'(c);
            @(negedge clock);
            if (bus.rd_valid) begin
                nv++;
                if (bus.rd_data != 0) nz++;
            end
            step();
        end
        idle();
        chk("lit_readback_count", nv, 128);
        chk("lit_readback_nonzero", nz, 0);

        // reset in the middle of a sweep
        fill(32'hA5A5_A5A5);
        for (int c = 0; c < 24; c++) begin
            clr_start = (c == 0);
            if (c == 20) reset = 1;
            if (c == 22) reset = 0;
            @(negedge clock);
            if (c == 19) chk("lit_busy_c19", busy, 1);
            if (c == 20) begin
                chk("lit_rst_busy_c20", busy, 0);
                chk("lit_rst_done_c20", clr_done, 0);
                chk("lit_rst_valid_c20", bus.rd_valid, 0);
            end
            step();
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            bus.rd_req  = (c < 3);
            bus.rd_addr = (c == 0) ? 7'd18 : (c == 1) ? 7'd19 : 7'd127;
            @(negedge clock);
            if (c == 2) chk("lit_addr18", bus.rd_data, 32'h0);
            if (c == 3) chk("lit_addr19", bus.rd_data, 32'hA5A5_A5A5);
            if (c == 4) chk("lit_addr127", bus.rd_data, 32'hA5A5_A5A5);
            step();
        end
        idle();

        // randomized traffic; a refused requester holds its request and operands
        pend_w = 0; pend_r = 0;
        for (int c = 0; c < 4000; c++) begin
            if (reset) reset = 0;
            else if ($urandom_range(0, 699) == 0) reset = 1;
            if (!pend_w) begin
                bus.wr_req  = ($urandom_range(0, 2) == 0);
                bus.wr_addr = AW'($urandom_range(0, 15));
                bus.wr_data = $urandom;
            end
            if (!pend_r) begin
                bus.rd_req  = ($urandom_range(0, 1) == 0);
                bus.rd_addr = AW'($urandom_range(0, 15));
            end
            clr_start = ($urandom_range(0, 199) == 0);
            @(negedge clock);
            pend_w = bus.wr_req && !bus.wr_gnt && !reset;
            pend_r = bus.rd_req && !bus.rd_gnt && !reset;
            step();
        end
        reset = 0; idle();
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/res_mem_ctrl.md
# res_mem_ctrl

Arbiter and sequencer for the single-port result RAM (`res_mem`, M4K, registered output) in the ModExp core. It shares the one RAM port between the datapath writer, which stores result words, and the host reader, which unloads them. It also provides a self-timed clear sweep that zeroes the whole RAM before a new exponentiation. It sits between the datapath/host interfaces and the `res_mem` instance, driving its `address`/`data`/`wren` and capturing its `q`.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (7): RAM address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): RAM word width.
- `TOTAL_ADDR`, default `` `TOTAL_ADDR `` (128): number of words; must be ≤ 2^ADDR_WIDTH.

Ports:
- `clock`  in  1  single clock for everything.
- `reset`  in  1  asynchronous, active-high.
- `wr_req`  in  1  datapath requests a write this cycle.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write word.
- `wr_gnt`  out  1  write accepted this cycle (combinational).
- `rd_req`  in  1  host requests a read this cycle.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_gnt`  out  1  read accepted this cycle (combinational).
- `rd_valid`  out  1  `rd_data` valid (registered).
- `rd_data`  out  DATA_WIDTH  read word; equals `ram_q` when `rd_valid`=1.
- `clr_start`  in  1  single-cycle pulse that starts the clear sweep.
- `busy`  out  1  clear sweep in progress.
- `clr_done`  out  1  one-cycle pulse when the sweep finishes.
- `ram_address`  out  ADDR_WIDTH  to `res_mem.address`.
- `ram_data`  out  DATA_WIDTH  to `res_mem.data`.
- `ram_wren`  out  1  write enable to the RAM wrapper.
- `ram_q`  in  DATA_WIDTH  from `res_mem.q`.

## Operation
FSM states:
- **SERVE**: reset state.
  - At most one grant per cycle.
  - If only one of `wr_req`/`rd_req` is asserted, that requester is granted.
  - If both are asserted, round-robin applies: the requester that did not win the last contended cycle is granted. A `last` flag updates only on contended cycles. Its reset value is "read", so write wins the first tie.
  - An ungranted requester must hold its request and operands; nothing is queued.
- **CLEAR**: entered on the edge after `clr_start`=1 is sampled in SERVE.
  - A counter runs 0..TOTAL_ADDR-1 and writes one zero word per cycle.
  - `wr_gnt`=`rd_gnt`=0 and `busy`=1 throughout.
  - After the write to TOTAL_ADDR-1, the FSM returns to SERVE and `clr_done` pulses in the first SERVE cycle.
- `clr_start` sampled in CLEAR is ignored.
- In the cycle `clr_start` is sampled in SERVE, normal arbitration still happens.

RAM drive (combinational mux):
- Write grant: `ram_address`=`wr_addr`, `ram_data`=`wr_data`, `ram_wren`=1.
- Read grant: `ram_address`=`rd_addr`, `ram_wren`=0.
- CLEAR: `ram_address`=counter, `ram_data`=0, `ram_wren`=1.
- No grant: `ram_wren`=0, `ram_address`=0, `ram_data`=0.

Read return:
- A 2-stage valid shift register is loaded with `rd_gnt`.
- `rd_valid` is stage 2; `rd_data` is wired to `ram_q`.
- Reads in flight when CLEAR starts still complete with their correct data.

## Timing
- Grant is combinational in the request cycle N. The RAM registers the address/data at edge N→N+1.
- Write data is present in the RAM after edge N→N+1. A read granted at N+1 to the same address returns the new data.
- Read latency is 2: a read granted in cycle N gives `rd_valid`=1 with `rd_data` in cycle N+2. Back-to-back reads produce back-to-back `rd_valid`.
- CLEAR lasts exactly TOTAL_ADDR cycles. `clr_start` sampled at cycle N gives:
  - `busy` high over cycles N+1..N+TOTAL_ADDR;
  - `clr_done` high at N+TOTAL_ADDR+1;
  - grants possible again at N+TOTAL_ADDR+1.
- Reset values: state=SERVE, counter=0, `last`=read, valid pipe=0, `busy`=0, `clr_done`=0, `rd_valid`=0.
- While `reset`=1:
  - `wr_gnt`, `rd_gnt` and `ram_wren` are forced to 0.
  - `rd_data` follows `ram_q` and is don't-care.
- Reset mid-CLEAR aborts the sweep immediately; the RAM is left partially cleared and no `clr_done` is issued.
- Reset drops in-flight reads; no `rd_valid` appears for them.

## Test plan
- Single write then read: `wr_req` addr 5 data 0xDEADBEEF at cycle 0, `rd_req` addr 5 at cycle 1 → `wr_gnt`@0, `rd_gnt`@1, `rd_valid`=1 with `rd_data`=0xDEADBEEF @3.
- Contention: `wr_req` and `rd_req` held high for 4 cycles (addresses 1 and 2) → grants alternate W,R,W,R; `ram_wren` is 1,0,1,0; `rd_valid` at cycles 3 and 5.
- Clear: fill addresses 0..127 with 0xA5A5A5A5, pulse `clr_start` at cycle 0 → `busy` high for cycles 1..128, `clr_done` at 129, no grants during 1..128; reading all 128 addresses afterwards returns 0.
- Ignore during busy: second `clr_start` at cycle 50 of the sweep → `clr_done` still at 129 only, single pulse.
- Reset mid-clear: assert `reset` at cycle 20 of the sweep → `busy`, `clr_done` and `rd_valid` go to 0 immediately; after release, addresses 0..18 read 0 and address 127 reads 0xA5A5A5A5.
- In-flight read across clear: read addr 3 granted in the same cycle `clr_start` is sampled → `rd_valid` two cycles later with the pre-clear value of addr 3.
